// File: rtl/ps2_keyboard_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : ps2_keyboard_rx
//  Purpose  : PS/2 keyboard receiver. Conditions the raw PS/2 lines, frames
//             start/data/parity/stop bytes, folds F0/E0 prefixes into
//             break/extended qualifiers and reports framing errors.
//  Revision : 1.0  initial release
// ============================================================================
module ps2_keyboard_rx #(
   parameter int FILTER_LEN  = 8,
   parameter int TIMEOUT_CYC = 25000
) (
   input  logic       pixel_clk,
   input  logic       reset,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] key_code,
   output logic       key_valid,
   output logic       key_break,
   output logic       key_ext,
   output logic       frame_err
);

   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [FW-1:0] C_FILT_LAST = FW'(FILTER_LEN - 1);
   localparam logic [TW-1:0] C_TMO_LAST  = TW'(TIMEOUT_CYC - 1);

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

   // Two-stage synchronisers; both lines idle high.
   logic clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;

   logic          filt_clk_q, filt_clk_d;
   logic [FW-1:0] filt_cnt_q, filt_cnt_d;
   logic          fall;

   state_t        state_q, state_d;
   logic [2:0]    bit_cnt_q, bit_cnt_d;
   logic [7:0]    sr_q, sr_d;
   logic          par_q, par_d;
   logic          pend_break_q, pend_break_d;
   logic          pend_ext_q, pend_ext_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic [7:0]    key_code_q, key_code_d;
   logic          key_valid_q, key_valid_d;
   logic          key_break_q, key_break_d;
   logic          key_ext_q, key_ext_d;
   logic          frame_err_q, frame_err_d;
   logic          abort;

   // Bring the asynchronous PS/2 lines into the pixel_clk domain.
   always_ff @(posedge pixel_clk or negedge reset) begin
      if (!reset) begin
         clk_s1_q <= 1'b1;
         clk_s2_q <= 1'b1;
         dat_s1_q <= 1'b1;
         dat_s2_q <= 1'b1;
      end else begin
         clk_s1_q <= ps2_clk;
         clk_s2_q <= clk_s1_q;
         dat_s1_q <= ps2_data;
         dat_s2_q <= dat_s1_q;
      end
   end

   // Glitch filter: the filtered clock follows only after FILTER_LEN differing samples in a row.
   always_comb begin
      filt_clk_d = filt_clk_q;
      filt_cnt_d = '0;
      if (clk_s2_q != filt_clk_q) begin
         if (filt_cnt_q == C_FILT_LAST) begin
            filt_clk_d = clk_s2_q;
         end else begin
            filt_cnt_d = filt_cnt_q + FW'(1);
         end
      end
   end

   // A fall event is seen in the same cycle the filtered clock is about to drop.
   assign fall = filt_clk_q & ~filt_clk_d;

   // Frame state machine, prefix tracking and mid-frame timeout.
   always_comb begin
      state_d      = state_q;
      bit_cnt_d    = bit_cnt_q;
      sr_d         = sr_q;
      par_d        = par_q;
      pend_break_d = pend_break_q;
      pend_ext_d   = pend_ext_q;
      tmo_d        = '0;
      key_code_d   = key_code_q;
      key_break_d  = key_break_q;
      key_ext_d    = key_ext_q;
      key_valid_d  = 1'b0;
      frame_err_d  = 1'b0;
      abort        = 1'b0;

      // A fall in the terminal cycle keeps the frame alive.
      if (state_q != IDLE && !fall) begin
         if (tmo_q == C_TMO_LAST) begin
            abort = 1'b1;
         end else begin
            tmo_d = tmo_q + TW'(1);
         end
      end

      case (state_q)
         IDLE: begin
            if (fall && !dat_s2_q) begin
               state_d   = DATA;
               bit_cnt_d = 3'd0;
            end
         end
         DATA: begin
            if (fall) begin
               sr_d      = {dat_s2_q, sr_q[7:1]};
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  state_d = PARITY;
               end
            end
         end
         PARITY: begin
            if (fall) begin
               par_d   = dat_s2_q;
               state_d = STOP;
            end
         end
         STOP: begin
            if (fall) begin
               state_d = IDLE;
               if (dat_s2_q && (^{sr_q, par_q})) begin
                  if (sr_q == 8'hF0) begin
                     pend_break_d = 1'b1;
                  end else if (sr_q == 8'hE0) begin
                     pend_ext_d = 1'b1;
                  end else begin
                     key_code_d   = sr_q;
                     key_break_d  = pend_break_q;
                     key_ext_d    = pend_ext_q;
                     key_valid_d  = 1'b1;
                     pend_break_d = 1'b0;
                     pend_ext_d   = 1'b0;
                  end
               end else begin
                  frame_err_d  = 1'b1;
                  pend_break_d = 1'b0;
                  pend_ext_d   = 1'b0;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (abort) begin
         state_d      = IDLE;
         frame_err_d  = 1'b1;
         pend_break_d = 1'b0;
         pend_ext_d   = 1'b0;
         tmo_d        = '0;
      end
   end

   // State and output registers.
   always_ff @(posedge pixel_clk or negedge reset) begin
      if (!reset) begin
         filt_clk_q   <= 1'b1;
         filt_cnt_q   <= '0;
         state_q      <= IDLE;
         bit_cnt_q    <= 3'd0;
         sr_q         <= 8'h00;
         par_q        <= 1'b0;
         pend_break_q <= 1'b0;
         pend_ext_q   <= 1'b0;
         tmo_q        <= '0;
         key_code_q   <= 8'h00;
         key_valid_q  <= 1'b0;
         key_break_q  <= 1'b0;
         key_ext_q    <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         filt_clk_q   <= filt_clk_d;
         filt_cnt_q   <= filt_cnt_d;
         state_q      <= state_d;
         bit_cnt_q    <= bit_cnt_d;
         sr_q         <= sr_d;
         par_q        <= par_d;
         pend_break_q <= pend_break_d;
         pend_ext_q   <= pend_ext_d;
         tmo_q        <= tmo_d;
         key_code_q   <= key_code_d;
         key_valid_q  <= key_valid_d;
         key_break_q  <= key_break_d;
         key_ext_q    <= key_ext_d;
         frame_err_q  <= frame_err_d;
      end
   end

   assign key_code  = key_code_q;
   assign key_valid = key_valid_q;
   assign key_break = key_break_q;
   assign key_ext   = key_ext_q;
   assign frame_err = frame_err_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_keyboard_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_ps2_keyboard_rx
//  Purpose  : Directed self-checking bench for ps2_keyboard_rx. A shortened
//             bit period and timeout keep run time small; the 1.2x-timeout
//             idle scales with them.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ps2_keyboard_rx;

   localparam int HALF    = 40;   // pixel_clk cycles per PS/2 clock half period
   localparam int TIMEOUT = 500;

   logic       pixel_clk = 1'b0;
   logic       reset     = 1'b0;
   logic       ps2_clk   = 1'b1;
   logic       ps2_data  = 1'b1;
   logic [7:0] key_code;
   logic       key_valid, key_break, key_ext, frame_err;

   int vectors     = 0;
   int miscompares = 0;
   int vcnt        = 0;   // key_valid high cycles seen
   int ecnt        = 0;   // frame_err high cycles seen
   int v0, e0;

   ps2_keyboard_rx #(.FILTER_LEN(8), .TIMEOUT_CYC(TIMEOUT)) dut (
      .pixel_clk (pixel_clk),
      .reset     (reset),
      .ps2_clk   (ps2_clk),
      .ps2_data  (ps2_data),
      .key_code  (key_code),
      .key_valid (key_valid),
      .key_break (key_break),
      .key_ext   (key_ext),
      .frame_err (frame_err)
   );

   always #20 pixel_clk = ~pixel_clk;

   // Count strobe cycles away from the active edge.
   always @(negedge pixel_clk) begin
      if (key_valid === 1'b1) vcnt++;
      if (frame_err === 1'b1) ecnt++;
   end

   task automatic ps2_bit(input logic v);
      ps2_data = v;
      repeat (HALF) @(posedge pixel_clk);
      ps2_clk = 1'b0;
      repeat (HALF) @(posedge pixel_clk);
      ps2_clk = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic bad_par);
      logic [10:0] f;
      f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
      for (int i = 0; i < 11; i++) ps2_bit(f[i]);
      ps2_data = 1'b1;
      repeat (HALF) @(posedge pixel_clk);
   endtask

   task automatic check_key(input string name, input int dv, input logic [7:0] code,
                            input logic brk, input logic ext);
      vectors++;
      if ((vcnt - v0) !== dv || (ecnt - e0) !== 0) begin
         miscompares++;
         $display("FAIL %s_strobes valid=%0d err=%0d want valid=%0d err=0", name, vcnt - v0, ecnt - e0, dv);
      end
      vectors++;
      if (key_code !== code || key_break !== brk || key_ext !== ext) begin
         miscompares++;
         $display("FAIL %s_key got code=%h brk=%b ext=%b want code=%h brk=%b ext=%b",
                  name, key_code, key_break, key_ext, code, brk, ext);
      end
   endtask

   task automatic test_reset();
      repeat (5) @(posedge pixel_clk);
      @(negedge pixel_clk);
      vectors++;
      if ({key_code, key_valid, key_break, key_ext, frame_err} !== 12'h000) begin
         miscompares++;
         $display("FAIL reset_outputs got code=%h v=%b b=%b e=%b err=%b want all 0",
                  key_code, key_valid, key_break, key_ext, frame_err);
      end
      reset = 1'b1;
      repeat (20) @(posedge pixel_clk);
   endtask

   task automatic test_make();
      v0 = vcnt; e0 = ecnt;
      send_frame(8'h1C, 1'b0);
      check_key("make_1c", 1, 8'h1C, 1'b0, 1'b0);
   endtask

   task automatic test_break();
      v0 = vcnt; e0 = ecnt;
      send_frame(8'hF0, 1'b0);
      vectors++;
      if ((vcnt - v0) !== 0) begin
         miscompares++;
         $display("FAIL break_prefix_valid got %0d want 0", vcnt - v0);
      end
      send_frame(8'h1C, 1'b0);
      check_key("break_1c", 1, 8'h1C, 1'b1, 1'b0);
   endtask

   task automatic test_ext_break();
      v0 = vcnt; e0 = ecnt;
      send_frame(8'hE0, 1'b0);
      send_frame(8'hF0, 1'b0);
      send_frame(8'h75, 1'b0);
      check_key("ext_brk_75", 1, 8'h75, 1'b1, 1'b1);
      v0 = vcnt; e0 = ecnt;
      send_frame(8'h1C, 1'b0);
      check_key("after_ext_1c", 1, 8'h1C, 1'b0, 1'b0);
   endtask

   task automatic test_parity_err();
      v0 = vcnt; e0 = ecnt;
      send_frame(8'h55, 1'b0);
      check_key("pre_parity_55", 1, 8'h55, 1'b0, 1'b0);
      v0 = vcnt; e0 = ecnt;
      send_frame(8'h1C, 1'b1);
      vectors++;
      if ((ecnt - e0) !== 1 || (vcnt - v0) !== 0 || key_code !== 8'h55) begin
         miscompares++;
         $display("FAIL parity_err got err=%0d valid=%0d code=%h want err=1 valid=0 code=55",
                  ecnt - e0, vcnt - v0, key_code);
      end
      send_frame(8'hF0, 1'b0);
      send_frame(8'h1C, 1'b1);
      v0 = vcnt; e0 = ecnt;
      send_frame(8'h1C, 1'b0);
      check_key("break_cleared_1c", 1, 8'h1C, 1'b0, 1'b0);
   endtask

   task automatic test_timeout();
      send_frame(8'hF0, 1'b0);
      v0 = vcnt; e0 = ecnt;
      ps2_bit(1'b0);
      ps2_bit(1'b1);
      ps2_bit(1'b0);
      ps2_bit(1'b1);
      ps2_data = 1'b1;
      repeat (TIMEOUT - 100) @(posedge pixel_clk);
      @(negedge pixel_clk);
      vectors++;
      if ((ecnt - e0) !== 0) begin
         miscompares++;
         $display("FAIL timeout_early got err=%0d want 0", ecnt - e0);
      end
      repeat (200) @(posedge pixel_clk);
      @(negedge pixel_clk);
      vectors++;
      if ((ecnt - e0) !== 1 || (vcnt - v0) !== 0) begin
         miscompares++;
         $display("FAIL timeout_err got err=%0d valid=%0d want err=1 valid=0", ecnt - e0, vcnt - v0);
      end
      v0 = vcnt; e0 = ecnt;
      send_frame(8'h2D, 1'b0);
      check_key("after_tmo_2d", 1, 8'h2D, 1'b0, 1'b0);
   endtask

   task automatic test_glitch();
      v0 = vcnt; e0 = ecnt;
      ps2_data = 1'b0;
      repeat (5) @(posedge pixel_clk);
      ps2_clk = 1'b0;
      #100;
      ps2_clk = 1'b1;
      repeat (50) @(posedge pixel_clk);
      ps2_data = 1'b1;
      repeat (TIMEOUT / 2) @(posedge pixel_clk);
      vectors++;
      if ((vcnt - v0) !== 0 || (ecnt - e0) !== 0) begin
         miscompares++;
         $display("FAIL glitch_quiet got valid=%0d err=%0d want 0 0", vcnt - v0, ecnt - e0);
      end
      v0 = vcnt; e0 = ecnt;
      send_frame(8'h1C, 1'b0);
      check_key("after_glitch_1c", 1, 8'h1C, 1'b0, 1'b0);
   endtask

   task automatic test_reset_midframe();
      logic [7:0] b;
      b = 8'h1C;
      send_frame(8'hE0, 1'b0);
      send_frame(8'h5A, 1'b0);
      v0 = vcnt; e0 = ecnt;
      ps2_bit(1'b0);
      for (int i = 0; i < 5; i++) ps2_bit(b[i]);
      ps2_data = b[5];
      repeat (HALF / 2) @(posedge pixel_clk);
      reset = 1'b0;
      repeat (3) @(posedge pixel_clk);
      @(negedge pixel_clk);
      vectors++;
      if ({key_code, key_valid, key_break, key_ext, frame_err} !== 12'h000) begin
         miscompares++;
         $display("FAIL midframe_reset got code=%h v=%b b=%b e=%b err=%b want all 0",
                  key_code, key_valid, key_break, key_ext, frame_err);
      end
      ps2_data = 1'b1;
      repeat (HALF) @(posedge pixel_clk);
      reset = 1'b1;
      repeat (20) @(posedge pixel_clk);
      v0 = vcnt; e0 = ecnt;
      send_frame(8'h1C, 1'b0);
      check_key("after_reset_1c", 1, 8'h1C, 1'b0, 1'b0);
   endtask

   initial begin
      test_reset();
      test_make();
      test_break();
      test_ext_break();
      test_parity_err();
      test_timeout();
      test_glitch();
      test_reset_midframe();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
